seg_display_scanner: RTL

Time-multiplexed driver for the board's six-digit common-anode seven-segment display. It holds one hex digit, decimal point and enable per position, written by the core over a simple strobe interface. It scans the positions round-robin, with an inter-digit blanking gap to suppress ghosting. It sits inside SystemChip, directly upstream of the `Segment`/`Digital` pins.

---
 rtl/seg_display_scanner.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Time-multiplexed driver for a six-digit common-anode seven-segment
//   display. The core writes a hex value, decimal point and enable per
//   position. The scanner visits positions 0..5 round-robin. Each slot
//   opens with a blanking gap, during which every digit select is off, to
//   suppress ghosting.
//
// Parameters
//   SCAN_DIV      cycles per digit slot (>= 2)
//   BLANK_CYCLES  blanking cycles at the start of each slot (< SCAN_DIV)
//
// Ports
//   Clock      system clock, rising edge
//   Reset      asynchronous, active-high; clears all state and outputs
//   WrEn       write strobe
//   WrAddr     digit position 0..5 (0 = rightmost); 6/7 ignored
//   WrData     [3:0] hex value, [4] decimal point, [5] digit enable
//   Segment    {dp,g,f,e,d,c,b,a}, active-low, registered
//   Digital    digit select, one-hot active-low, registered
//   FrameTick  one-cycle pulse on the last cycle of each six-slot frame
module seg_display_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       WrEn,
  input  logic [2:0] WrAddr,
  input  logic [5:0] WrData,
  output logic [7:0] Segment,
  output logic [5:0] Digital,
  output logic       FrameTick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      idx, idx_nx;
  logic [5:0]      ent [6];
  logic [5:0]      entry;
  logic [7:0]      seg_nx;
  logic [5:0]      dig_nx;
  logic            tick_nx;

  // Active-low pattern for a hex digit; dp on pulls bit 7 low.
  function automatic logic [7:0] decode(input logic [3:0] v, input logic dp);
    logic [7:0] p;
    case (v)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    p[7] = ~dp;
    return p;
  endfunction

  // Digit register file
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 6; i++) ent[i] <= '0;
    end else if (WrEn && WrAddr <= 3'd5) begin
      ent[WrAddr] <= WrData;
    end
  end

  // Scan state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next scan position
  always_comb begin
    cnt_nx = cnt + CW'(1);
    idx_nx = idx;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    state_nx = (cnt_nx < BLANK_END) ? BLANK : SHOW;
  end

  // Output decode, evaluated for the upcoming cycle so that the output
  // registers line up with cnt/idx. Reading the register file here gives
  // a write at edge k its appearance on Segment at edge k+1.
  always_comb begin
    entry   = ent[idx_nx];
    seg_nx  = 8'hFF;
    dig_nx  = 6'h3F;
    if (state_nx == SHOW && entry[5]) begin
      seg_nx = decode(entry[3:0], entry[4]);
      dig_nx = ~(6'd1 << idx_nx);
    end
    tick_nx = (cnt_nx == CNT_LAST) && (idx_nx == 3'd5);
  end

  // Output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Segment   <= 8'hFF;
      Digital   <= 6'h3F;
      FrameTick <= 1'b0;
    end else begin
      Segment   <= seg_nx;
      Digital   <= dig_nx;
      FrameTick <= tick_nx;
    end
  end

endmodule
